instr_cache_fill_ctrl: RTL and testbench
========================================

// Module: instr_cache_fill_ctrl
// PURPOSE
//  Memory-side fill engine for the multi-cycle instruction cache set.
//  On a cache miss it issues one burst read to backing memory and buffers the whole block.
//  It then streams the block as back-to-back 64-bit beats on the set's replacement interface (rep_active/rep_word).
//  It never returns data in the cycle the miss is raised.
// PARAMETERS
//  B       64  block size in bytes; power of 2, >=16; BEATS = B/8 64-bit beats per block
//  ADDR_W  32  byte-address width
// PORTS
//  clk_i         in   1       clock; all state updates on rising edge
//  reset_i       in   1       synchronous reset, active-low (0 = reset)
//  miss_i        in   1       cache set miss for the current fetch
//  miss_addr_i   in   ADDR_W  fetch address of the miss
//  flush_i       in   1       pipeline flush; cancels a fill that has not started streaming
//  rep_active_o  out  1       high during a streaming beat to the cache set
//  rep_word_o    out  64      beat data; beat k = block bytes [8k+7:8k]
//  fill_busy_o   out  1       high in every state except IDLE
//  fill_done_o   out  1       one-cycle pulse in the cycle of the last streamed beat
//  mem_req_o     out  1       burst read request, held until accepted
//  mem_addr_o    out  ADDR_W  block-aligned base address: {miss_addr[ADDR_W-1:log2 B], 0}
//  mem_ready_i   in   1       memory accepts the request this cycle
//  mem_rvalid_i  in   1       read beat valid; in-order; gaps allowed
//  mem_rdata_i   in   64      read beat data
// BEHAVIOUR
//  Reset (reset_i=0 at an edge):
//   - state=IDLE; all counters, abort flag and rep_word_o cleared to 0
//   - outputs 0: rep_active_o, fill_busy_o, fill_done_o, mem_req_o, mem_addr_o
//   - reset overrides any state, including mid-COLLECT and mid-STREAM
//   - after reset, memory beats of the abandoned burst are ignored because the block is in IDLE
//  States:
//   - IDLE: miss_i=1 & flush_i=0 -> latch aligned base into mem_addr_o, go REQ.
//   - REQ: mem_req_o=1, address stable. On mem_ready_i -> COLLECT; mem_req_o drops the next cycle.
//     flush_i in REQ before acceptance -> IDLE with no request issued.
//     flush_i in the acceptance cycle -> COLLECT with the abort flag set.
//   - COLLECT: each mem_rvalid_i writes buf[rcnt], then rcnt++.
//     The beat with rcnt==BEATS-1 goes to DRAIN_END if abort is set, else to STREAM.
//     flush_i in COLLECT sets abort; the burst is still fully drained and never cancelled.
//   - STREAM: rep_active_o=1 for exactly BEATS consecutive cycles; rep_word_o=buf[scnt]; scnt++ each cycle.
//     At scnt==BEATS-1: fill_done_o=1, go DONE. flush_i is ignored in STREAM.
//   - DONE: single cycle; miss_i ignored so a stale registered miss cannot relaunch; -> IDLE.
//   - DRAIN_END: single cycle; clear abort; -> IDLE. fill_done_o stays 0 and nothing is streamed.
//  Timing and width rules:
//   - Latency: the first beat is streamed 1 cycle after the last memory beat is captured.
//     With zero-wait memory, a miss at cycle 0 streams on cycles BEATS+3 .. 2*BEATS+2.
//   - rep_word_o=0 whenever rep_active_o=0.
//   - mem_rvalid_i outside COLLECT is ignored.
//   - rcnt and scnt are $clog2(BEATS) bits wide and wrap to 0 on the final beat.
//   - Simultaneous last-rvalid and flush_i: abort wins -> DRAIN_END.
//   - miss_i is only sampled in IDLE; new misses while busy are dropped, and the cache re-raises them.
// TESTING (B=64, BEATS=8)
//  1. Zero-wait memory.
//     Stimulus: miss_addr 0x0000_1234; rdata beat k = 64'hA000_0000_0000_000k.
//     Required: mem_addr_o 0x0000_1200; rep_active_o high 8 consecutive cycles carrying beats 0..7 in order;
//     fill_done_o on beat 7; then DONE, then IDLE.
//  2. Backpressure and gaps.
//     Stimulus: mem_ready_i low 5 cycles; rvalid on alternate cycles.
//     Required: mem_req_o and mem_addr_o stable while waiting; streaming output identical to test 1,
//     with no gaps in rep_active_o.
//  3. Flush in COLLECT after 3 beats.
//     Required: remaining 5 beats absorbed; rep_active_o and fill_done_o never assert; fill_busy_o=0 after DRAIN_END.
//  4. Flush in REQ before mem_ready_i.
//     Required: back to IDLE next cycle; no COLLECT entered; a later miss at 0x40 fills correctly.
//  5. reset_i=0 during STREAM beat 4.
//     Required: rep_active_o=0 next cycle; stray rvalids ignored; a fresh miss fills correctly.
//  6. miss_i held high through the DONE cycle.
//     Required: exactly one memory request per fill; the flush_i in STREAM does not truncate the 8 beats.

Source files
------------

// File: rtl/instr_cache_fill_ctrl.sv
// Instruction-cache fill engine: issues one burst read per miss, buffers the block,
// then streams it as back-to-back 64-bit beats into the cache set.
module instr_cache_fill_ctrl #(
   parameter int unsigned B      = 64,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              miss_i,
   input  logic [ADDR_W-1:0] miss_addr_i,
   input  logic              flush_i,
   output logic              rep_active_o,
   output logic [63:0]       rep_word_o,
   output logic              fill_busy_o,
   output logic              fill_done_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ready_i,
   input  logic              mem_rvalid_i,
   input  logic [63:0]       mem_rdata_i
);

   localparam int unsigned Beats = B / 8;
   localparam int unsigned CntW  = $clog2(Beats);
   localparam int unsigned OffW  = $clog2(B);
   localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StCollect,
      StStream,
      StDone,
      StDrainEnd
   } state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   rcnt_q, rcnt_d;
   logic [CntW-1:0]   scnt_q, scnt_d;
   logic              abort_q, abort_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              req_q, req_d;
   logic              rep_active_q, rep_active_d;
   logic [63:0]       rep_word_q, rep_word_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic [63:0]       blk_q [Beats];
   logic              blk_we;

   // Offset bits of the miss address never reach memory: fills are block-aligned.
   logic unused_addr_bits;
   assign unused_addr_bits = ^miss_addr_i[OffW-1:0];

   always_comb begin
      state_d      = state_q;
      rcnt_d       = rcnt_q;
      scnt_d       = scnt_q;
      abort_d      = abort_q;
      addr_d       = addr_q;
      req_d        = 1'b0;
      rep_active_d = 1'b0;
      rep_word_d   = '0;
      done_d       = 1'b0;
      blk_we       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (miss_i && !flush_i) begin
               addr_d  = {miss_addr_i[ADDR_W-1:OffW], {OffW{1'b0}}};
               req_d   = 1'b1;
               state_d = StReq;
            end
         end
         StReq: begin
            // Acceptance wins over flush: the burst is in flight and must be drained.
            if (mem_ready_i) begin
               abort_d = flush_i;
               state_d = StCollect;
            end else if (flush_i) begin
               state_d = StIdle;
            end else begin
               req_d = 1'b1;
            end
         end
         StCollect: begin
            if (flush_i) begin
               abort_d = 1'b1;
            end
            if (mem_rvalid_i) begin
               blk_we = 1'b1;
               rcnt_d = rcnt_q + 1'b1;
               if (rcnt_q == LastBeat) begin
                  state_d = (abort_q || flush_i) ? StDrainEnd : StStream;
               end
            end
         end
         StStream: begin
            rep_active_d = 1'b1;
            rep_word_d   = blk_q[scnt_q];
            scnt_d       = scnt_q + 1'b1;
            if (scnt_q == LastBeat) begin
               done_d  = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         StDrainEnd: begin
            abort_d = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q      <= StIdle;
         rcnt_q       <= '0;
         scnt_q       <= '0;
         abort_q      <= 1'b0;
         addr_q       <= '0;
         req_q        <= 1'b0;
         rep_active_q <= 1'b0;
         rep_word_q   <= '0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rcnt_q       <= rcnt_d;
         scnt_q       <= scnt_d;
         abort_q      <= abort_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         rep_active_q <= rep_active_d;
         rep_word_q   <= rep_word_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   // Block buffer holds data only; its contents are meaningless until a fill overwrites it.
   always_ff @(posedge clk_i) begin
      if (blk_we) begin
         blk_q[rcnt_q] <= mem_rdata_i;
      end
   end

   assign rep_active_o = rep_active_q;
   assign rep_word_o   = rep_word_q;
   assign fill_busy_o  = busy_q;
   assign fill_done_o  = done_q;
   assign mem_req_o    = req_q;
   assign mem_addr_o   = addr_q;

endmodule

// File: tb/tb_instr_cache_fill_ctrl.sv
// Randomized scoreboard bench for instr_cache_fill_ctrl: the driver plays cache and memory,
// queues the beats a fill must stream, and a negedge monitor pops and compares them.
module tb_instr_cache_fill_ctrl;

   localparam int unsigned B     = 64;
   localparam int unsigned AddrW = 32;
   localparam int Beats = B / 8;

   localparam int MNone         = 0;
   localparam int MFlushReq     = 1;
   localparam int MFlushAccept  = 2;
   localparam int MFlushCollect = 3;
   localparam int MFlushLast    = 4;
   localparam int MFlushStream  = 5;
   localparam int MResetStream  = 6;

   logic             clk = 1'b0;
   logic             reset_i;
   logic             miss_i;
   logic [AddrW-1:0] miss_addr_i;
   logic             flush_i;
   logic             rep_active_o;
   logic [63:0]      rep_word_o;
   logic             fill_busy_o;
   logic             fill_done_o;
   logic             mem_req_o;
   logic [AddrW-1:0] mem_addr_o;
   logic             mem_ready_i;
   logic             mem_rvalid_i;
   logic [63:0]      mem_rdata_i;

   int cyc       = 0;
   int n_checks  = 0;
   int n_fail    = 0;
   int n_acc     = 0;
   int run_idx   = 0;
   int first_cyc = 0;
   logic [63:0] exp_q[$];

   instr_cache_fill_ctrl #(
      .B      (B),
      .ADDR_W (AddrW)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .miss_i       (miss_i),
      .miss_addr_i  (miss_addr_i),
      .flush_i      (flush_i),
      .rep_active_o (rep_active_o),
      .rep_word_o   (rep_word_o),
      .fill_busy_o  (fill_busy_o),
      .fill_done_o  (fill_done_o),
      .mem_req_o    (mem_req_o),
      .mem_addr_o   (mem_addr_o),
      .mem_ready_i  (mem_ready_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every streamed beat must be the next queued word, runs are gapless
   // and exactly Beats long, and done marks only the last beat of a run.
   always @(negedge clk) begin
      if (!reset_i) begin
         run_idx = 0;
      end else begin
         if (mem_req_o && mem_ready_i) n_acc++;
         if (rep_active_o) begin
            if (run_idx == 0) first_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected beat: got %0h, required no beat (cycle %0d)",
                        rep_word_o, cyc);
            end else begin
               check("rep_word", rep_word_o, exp_q.pop_front());
            end
            check("fill_done on beat", fill_done_o, (run_idx == Beats - 1));
            run_idx = (run_idx == Beats - 1) ? 0 : run_idx + 1;
         end else begin
            check("rep_word idle zero", rep_word_o, 64'd0);
            check("fill_done without beat", fill_done_o, 0);
            if (run_idx != 0) begin
               check("stream gap beat index", run_idx, 0);
            end
            run_idx = 0;
         end
      end
   end

   task automatic run_fill(input logic [31:0] addr, input int mode, input int fb,
                           input int rdy_dly, input int gaps, input bit hold, input bit patt);
      logic [31:0] exp_addr;
      logic [63:0] data;
      int c0, acc0, cnt;
      bit abort, seen;
      exp_addr = addr & ~32'(B - 1);
      abort = (mode == MFlushAccept) || (mode == MFlushCollect) || (mode == MFlushLast);
      acc0 = n_acc;
      miss_i = 1'b1;
      miss_addr_i = addr;
      c0 = cyc;
      tick();
      miss_i = hold;
      miss_addr_i = $urandom;
      check("req raised", mem_req_o, 1);
      check("mem_addr aligned", mem_addr_o, exp_addr);
      check("busy in req", fill_busy_o, 1);
      for (int i = 0; i < rdy_dly; i++) begin
         tick();
         check("req held", mem_req_o, 1);
         check("addr held", mem_addr_o, exp_addr);
      end
      if (mode == MFlushReq) begin
         miss_i = 1'b0;
         flush_i = 1'b1;
         tick();
         flush_i = 1'b0;
         check("req dropped by flush", mem_req_o, 0);
         check("idle after req flush", fill_busy_o, 0);
         tick();
         check("no request accepted", n_acc - acc0, 0);
         return;
      end
      mem_ready_i = 1'b1;
      flush_i = (mode == MFlushAccept);
      tick();
      mem_ready_i = 1'b0;
      flush_i = 1'b0;
      check("req dropped after accept", mem_req_o, 0);
      for (int k = 0; k < Beats; k++) begin
         if (mode == MFlushCollect && k == fb) begin
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
         end
         if (k > 0 && (gaps == 1 || (gaps == 2 && $urandom_range(0, 1) == 1))) tick();
         data = patt ? (64'hA000_0000_0000_0000 | 64'(k)) : {$urandom, $urandom};
         mem_rvalid_i = 1'b1;
         mem_rdata_i = data;
         flush_i = (mode == MFlushLast && k == Beats - 1);
         if (!abort) exp_q.push_back(data);
         tick();
         mem_rvalid_i = 1'b0;
         flush_i = 1'b0;
         mem_rdata_i = {$urandom, $urandom};
      end
      if (abort) begin
         check("busy in drain_end", fill_busy_o, 1);
         tick();
         check("idle after drain_end", fill_busy_o, 0);
         check("one request per aborted fill", n_acc - acc0, 1);
         return;
      end
      seen = 1'b0;
      cnt = 0;
      for (int i = 0; i < 4 * Beats && !seen; i++) begin
         flush_i = (mode == MFlushStream) && rep_active_o && ($urandom_range(0, 1) == 1);
         tick();
         flush_i = 1'b0;
         if (rep_active_o) cnt++;
         if (mode == MResetStream && cnt == 5) begin
            reset_i = 1'b0;
            miss_i = 1'b0;
            exp_q.delete();
            tick();
            check("rep_active cleared by reset", rep_active_o, 0);
            check("busy cleared by reset", fill_busy_o, 0);
            check("req cleared by reset", mem_req_o, 0);
            reset_i = 1'b1;
            for (int j = 0; j < 4; j++) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i = {$urandom, $urandom};
               tick();
               check("stray rvalid ignored", fill_busy_o, 0);
            end
            mem_rvalid_i = 1'b0;
            return;
         end
         if (fill_done_o) seen = 1'b1;
      end
      check("fill_done reached", seen, 1);
      if (rdy_dly == 0 && gaps == 0) begin
         check("first beat latency", first_cyc - c0, Beats + 3);
      end
      tick();
      miss_i = 1'b0;
      check("idle after done", fill_busy_o, 0);
      tick();
      check("no relaunch from stale miss", mem_req_o, 0);
      check("one request per fill", n_acc - acc0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int mode;
      reset_i = 1'b0;
      miss_i = 1'b1;
      miss_addr_i = 32'h0000_1234;
      flush_i = 1'b0;
      mem_ready_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = '0;
      tick();
      tick();
      check("reset rep_active", rep_active_o, 0);
      check("reset rep_word", rep_word_o, 0);
      check("reset busy", fill_busy_o, 0);
      check("reset done", fill_done_o, 0);
      check("reset req", mem_req_o, 0);
      check("reset addr", mem_addr_o, 0);
      miss_i = 1'b0;
      reset_i = 1'b1;
      tick();

      run_fill(32'h0000_1234, MNone, 0, 0, 0, 1'b0, 1'b1);
      run_fill(32'h0000_1234, MNone, 0, 5, 1, 1'b0, 1'b1);
      run_fill(32'h2000_0088, MFlushCollect, 3, 1, 0, 1'b0, 1'b0);
      run_fill(32'h0000_3300, MFlushReq, 0, 2, 0, 1'b0, 1'b0);
      run_fill(32'h0000_0040, MNone, 0, 0, 2, 1'b0, 1'b0);
      run_fill(32'h5555_5555, MResetStream, 0, 1, 0, 1'b0, 1'b0);
      run_fill(32'h0000_07fc, MNone, 0, 0, 0, 1'b0, 1'b0);
      run_fill(32'h0000_9abc, MFlushStream, 0, 0, 0, 1'b1, 1'b1);
      run_fill(32'hdead_beef, MFlushAccept, 0, 0, 2, 1'b0, 1'b0);
      run_fill(32'h1234_5678, MFlushLast, 0, 1, 0, 1'b0, 1'b0);
      run_fill(32'h0bad_f00d, MNone, 0, 2, 2, 1'b0, 1'b0);

      for (int n = 0; n < 24; n++) begin
         mode = $urandom_range(0, 5);
         run_fill($urandom, mode, $urandom_range(1, Beats - 1), $urandom_range(0, 4), 2,
                  (mode == MNone || mode == MFlushStream) && ($urandom_range(0, 1) == 1),
                  1'b0);
         repeat ($urandom_range(0, 2)) tick();
      end

      tick();
      tick();
      check("scoreboard drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
